// File: rtl/hack_loader_pkg.sv
// Shared types and widths for the Hack ROM loader receiver.
// Imported by the receiver and its bench.
package hack_loader_pkg;

  localparam int LOADER_DATA_WIDTH = 16;
  localparam int LOADER_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    WRITE    = 2'd2,
    RECEIVED = 2'd3
  } loader_state_t;

endpackage

// File: rtl/rom_loader_receiver.sv
// SoC-side responder for the ROM loading handshake.
// Writes loader words to consecutive ROM addresses via the SRAM write port.
module rom_loader_receiver
  import hack_loader_pkg::*;
#(
  parameter int DATA_WIDTH = LOADER_DATA_WIDTH,
  parameter int ADDR_WIDTH = LOADER_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rom_loader_reset,
  input  logic                  rom_loader_load,
  input  logic [DATA_WIDTH-1:0] rom_loader_data,
  output logic                  rom_loader_ack,
  output logic                  rom_loader_load_received,
  output logic                  mem_write_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_write_ack,
  output logic                  loading,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow
);

  loader_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  ack_q, ack_d;
  logic                  rcv_q, rcv_d;
  logic                  req_q, req_d;
  logic                  load_q, load_d;

  // ROM is full once the counter reaches 2^ADDR_WIDTH
  logic full;
  assign full = count_q[ADDR_WIDTH];

  // Next-state, datapath updates and registered output decode
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (rom_loader_reset) begin
          state_d = ARMED;
          addr_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ARMED: begin
        if (!rom_loader_reset) begin
          state_d = IDLE;
        end else if (rom_loader_load && !full) begin
          wdata_d = rom_loader_data;
          state_d = WRITE;
        end else if (rom_loader_load) begin
          ovf_d   = 1'b1;
          state_d = RECEIVED;
        end
      end
      WRITE: begin
        if (mem_write_ack) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          count_d = count_q + (ADDR_WIDTH+1)'(1);
          state_d = RECEIVED;
        end
      end
      RECEIVED: begin
        if (!rom_loader_load) begin
          state_d = rom_loader_reset ? ARMED : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ack_d  = (state_d != IDLE);
    load_d = (state_d != IDLE);
    req_d  = (state_d == WRITE);
    rcv_d  = (state_d == RECEIVED);
  end

  // State, datapath and output registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
      rcv_q   <= 1'b0;
      req_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      ack_q   <= ack_d;
      rcv_q   <= rcv_d;
      req_q   <= req_d;
      load_q  <= load_d;
    end
  end

  assign rom_loader_ack           = ack_q;
  assign rom_loader_load_received = rcv_q;
  assign mem_write_req            = req_q;
  assign mem_addr                 = addr_q;
  assign mem_wdata                = wdata_q;
  assign loading                  = load_q;
  assign word_count               = count_q;
  assign overflow                 = ovf_q;

endmodule
